// File: rtl/pipe_datapath.sv
// pipe_datapath: three-stage (issue/EX/WB) ALU datapath with register file.
// Optional forwarding when PIPE_DATAPATH_FORWARD_EN is defined, else hazards stall.
module pipe_datapath #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] rs1,
    input  logic [A_WIDTH-1:0] rs2,
    input  logic [A_WIDTH-1:0] rd,
    input  logic               reg_write,
    input  logic               alu_src,
    input  logic [D_WIDTH-1:0] imm,
    input  logic [2:0]         alu_ctrl,
    output logic [D_WIDTH-1:0] result,
    output logic               result_valid,
    output logic [A_WIDTH-1:0] result_rd,
    output logic               eq,
    output logic [D_WIDTH-1:0] a0
);

    localparam int NREG = 1 << A_WIDTH;
    localparam int SH   = $clog2(D_WIDTH);

    logic [D_WIDTH-1:0] regs [NREG];

    logic               ex_valid;
    logic               ex_we;
    logic [A_WIDTH-1:0] ex_rd;
    logic [2:0]         ex_ctrl;
    logic [D_WIDTH-1:0] ex_op1;
    logic [D_WIDTH-1:0] ex_op2;

    logic               wb_valid;
    logic               wb_we;
    logic [A_WIDTH-1:0] wb_rd;
    logic [D_WIDTH-1:0] wb_result;
    logic               wb_eq;

    logic [D_WIDTH-1:0] alu_out;
    logic [D_WIDTH-1:0] rf1;
    logic [D_WIDTH-1:0] rf2;
    logic [D_WIDTH-1:0] src1;
    logic [D_WIDTH-1:0] src2;
    logic [D_WIDTH-1:0] op2;
    logic               use2;
    logic               ex_m1;
    logic               ex_m2;
    logic               wb_m1;
    logic               wb_m2;
    logic               issue;

    // hazard matching against the writing ops in EX and WB; x0 never matches
    always_comb begin
        use2  = ~alu_src;
        ex_m1 = ex_valid && ex_we && (rs1 != '0) && (rs1 == ex_rd);
        wb_m1 = wb_valid && wb_we && (rs1 != '0) && (rs1 == wb_rd);
        ex_m2 = use2 && ex_valid && ex_we && (rs2 != '0) && (rs2 == ex_rd);
        wb_m2 = use2 && wb_valid && wb_we && (rs2 != '0) && (rs2 == wb_rd);
        rf1   = (rs1 == '0) ? '0 : regs[rs1];
        rf2   = (rs2 == '0) ? '0 : regs[rs2];
    end

`ifdef PIPE_DATAPATH_FORWARD_EN
    // operand select with bypass; the younger EX result wins over WB
    always_comb begin
        src1     = ex_m1 ? alu_out : (wb_m1 ? wb_result : rf1);
        src2     = ex_m2 ? alu_out : (wb_m2 ? wb_result : rf2);
        in_ready = 1'b1;
    end
`else
    // operands straight from the file; hold off issue until the producer retires
    always_comb begin
        src1     = rf1;
        src2     = rf2;
        in_ready = !(in_valid && (ex_m1 || wb_m1 || ex_m2 || wb_m2));
    end
`endif

    assign op2   = alu_src ? imm : src2;
    assign issue = in_valid && in_ready;

    // EX-stage ALU
    always_comb begin
        alu_out = '0;
        unique case (ex_ctrl)
            3'b000: alu_out = ex_op1 + ex_op2;
            3'b001: alu_out = ex_op1 - ex_op2;
            3'b010: alu_out = ex_op1 & ex_op2;
            3'b011: alu_out = ex_op1 | ex_op2;
            3'b100: alu_out = ex_op1 ^ ex_op2;
            3'b101: alu_out = ex_op1 << ex_op2[SH-1:0];
            3'b110: alu_out = ex_op1 >> ex_op2[SH-1:0];
            3'b111: alu_out = {{(D_WIDTH-1){1'b0}},
                               ($signed(ex_op1) < $signed(ex_op2))};
            default: alu_out = '0;
        endcase
    end

    // issue into EX: capture operands and control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
        end else begin
            ex_valid <= issue;
            if (issue) begin
                ex_we   <= reg_write;
                ex_rd   <= rd;
                ex_ctrl <= alu_ctrl;
                ex_op1  <= src1;
                ex_op2  <= op2;
            end
        end
    end

    // EX to WB: register ALU result and compare flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
            wb_eq     <= 1'b0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_we     <= ex_we;
                wb_rd     <= ex_rd;
                wb_result <= alu_out;
                wb_eq     <= (ex_op1 == ex_op2);
            end
        end
    end

    // register file write-back; reset wins so in-flight ops never land
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_valid && wb_we && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_result;
        end
    end

    assign result       = wb_result;
    assign result_valid = wb_valid;
    assign result_rd    = wb_rd;
    assign eq           = wb_eq;
    assign a0           = regs[10];

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath (A_WIDTH=5, D_WIDTH=32).
// Expected stall counts follow PIPE_DATAPATH_FORWARD_EN.
module tb_pipe_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, alu_src;
    logic [31:0] imm;
    logic [2:0]  alu_ctrl;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  result_rd;
    logic        eq;
    logic [31:0] a0;

`ifdef PIPE_DATAPATH_FORWARD_EN
    localparam int EXP_ST = 0;
`else
    localparam int EXP_ST = 2;
`endif

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, SLT = 3'd7;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        eq;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [32];
    int          vectors = 0;
    int          miscompares = 0;

    pipe_datapath #(.A_WIDTH(5), .D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .alu_src(alu_src), .imm(imm), .alu_ctrl(alu_ctrl),
        .result(result), .result_valid(result_valid),
        .result_rd(result_rd), .eq(eq), .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            SLL:  return a << b[4:0];
            SRL:  return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // present one op, wait out any stall, and book its expected result
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic we,
                         input logic src, input logic [31:0] im,
                         input logic [2:0] op, output int stalls);
        logic [31:0] a, b;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; rs1 = r1; rs2 = r2; rd = d;
        reg_write = we; alu_src = src; imm = im; alu_ctrl = op;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 10) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            a = model[r1];
            b = src ? im : model[r2];
            e.res = ref_alu(op, a, b);
            e.rd  = d;
            e.eq  = (a == b);
            sbq.push_back(e);
            if (we && d != 5'd0) model[d] = e.res;
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // compare each WB-stage output against the oldest booked op
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("result_rd", {27'd0, result_rd}, {27'd0, e.rd});
                chk("eq", {31'd0, eq}, {31'd0, e.eq});
            end
        end
    end

    initial begin
        int st;
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        reg_write = 1'b0; alu_src = 1'b0; imm = '0; alu_ctrl = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_rd", {27'd0, result_rd}, 32'd0);
        chk("rst_eq", {31'd0, eq}, 32'd0);
        chk("rst_a0", a0, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;

        // addi x10,x0,5 with latency checks
        issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'd5, ADD, st);
        idle(1);
        chk("addi_valid_ex", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("addi_valid_wb", {31'd0, result_valid}, 32'd1);
        chk("addi_result", result, 32'd5);
        @(negedge clk);
        chk("addi_a0", a0, 32'd5);

        // dependent chain
        issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd7, ADD, st);
        chk("chain_st1", st, 32'd0);
        issue(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0, ADD, st);
        chk("chain_st2", st, EXP_ST);
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0, SUB, st);
        chk("chain_st3", st, EXP_ST);
        chk("chain_x3", model[3], 32'hFFFF_FFF9);
        idle(3);

        // writes to x0 are dropped; x0 reads never stall
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9, ADD, st);
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'd0, ADD, st);
        chk("x0_stall", st, 32'd0);

        // non-writing producer and immediate op never stall
        issue(5'd0, 5'd0, 5'd16, 1'b0, 1'b1, 32'd3, ADD, st);
        issue(5'd16, 5'd0, 5'd17, 1'b1, 1'b1, 32'd0, ADD, st);
        chk("nowrite_stall", st, 32'd0);
        issue(5'd0, 5'd0, 5'd18, 1'b1, 1'b1, 32'd4, ADD, st);
        issue(5'd0, 5'd18, 5'd19, 1'b1, 1'b1, 32'd2, ADD, st);
        chk("imm_rs2_stall", st, 32'd0);

        // ALU sweep
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'd1, ADD, st);
        issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 32'd33, ADD, st);
        issue(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'd0, SLL, st);
        chk("sll_model", model[7], 32'd2);
        issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'h8000_0000, ADD, st);
        issue(5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 32'd31, SRL, st);
        issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'hFFFF_FFFF, ADD, st);
        issue(5'd11, 5'd5, 5'd12, 1'b1, 1'b0, 32'd0, SLT, st);
        issue(5'd5, 5'd11, 5'd20, 1'b1, 1'b0, 32'd0, SLT, st);
        issue(5'd5, 5'd5, 5'd13, 1'b1, 1'b0, 32'd0, XOR_, st);
        issue(5'd7, 5'd0, 5'd14, 1'b1, 1'b1, 32'hF0, OR_, st);
        issue(5'd11, 5'd0, 5'd21, 1'b1, 1'b1, 32'h0F0F, AND_, st);
        issue(5'd0, 5'd5, 5'd15, 1'b1, 1'b0, 32'd0, SUB, st);
        issue(5'd15, 5'd0, 5'd10, 1'b1, 1'b1, 32'd2, ADD, st);

        // drain and check architectural a0
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("drain", sbq.size(), 32'd0);
        idle(2);
        chk("a0_final", a0, model[10]);

        // reset with two ops in flight
        issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'd77, ADD, st);
        issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'd88, ADD, st);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        model_clear();
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("mid_rst_a0", a0, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        idle(3);
        chk("post_rst_a0", a0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
